// File: rtl/div_unit_pkg.sv
// Shared encodings for the iterative divider: FSM state codes and handshake levels
// used by div_unit and the execute-stage glue that drives it.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE = 2'b00,
    DIV_ZERO = 2'b01,
    DIV_ON   = 2'b10,
    DIV_END  = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for the execute stage: signed/unsigned 32-bit
// divide, returns {remainder, quotient} for HI/LO, stalls the pipe while iterating.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 stall_o
);

  localparam logic [5:0] LAST_CNT = 6'(ITER);

  div_state_e             state_q, state_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [2*WIDTH:0]       acc_q, acc_d;
  logic [WIDTH-1:0]       divisor_q, divisor_d;
  logic                   signed_q, signed_d;
  logic                   sign1_q, sign1_d;
  logic                   sign2_q, sign2_d;
  logic [2*WIDTH-1:0]     result_q, result_d;
  logic                   ready_q, ready_d;

  logic [WIDTH+1:0]       trial;
  logic [WIDTH-1:0]       quo_fix;
  logic [WIDTH-1:0]       rem_fix;
  logic                   go;
  logic                   keep;

  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic en);
    return (en && v[WIDTH-1]) ? neg2c(v) : v;
  endfunction

  // Trial subtract uses the full 33-bit partial remainder so large unsigned
  // divisors (top bit set) still produce a correct borrow in trial[WIDTH+1].
  assign trial   = {acc_q[2*WIDTH:WIDTH], acc_q[WIDTH-1]} - {2'b00, divisor_q};
  assign quo_fix = (signed_q && (sign1_q ^ sign2_q)) ? neg2c(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign rem_fix = (signed_q && sign1_q) ? neg2c(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
  assign go      = (start_i == DIV_START) && !annul_i;
  assign keep    = (start_i != DIV_STOP) && !annul_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    divisor_d = divisor_q;
    signed_d  = signed_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    result_d  = result_q;
    ready_d   = ready_q;

    unique case (state_q)
      DIV_FREE: begin
        result_d = '0;
        ready_d  = DIV_RESULT_NOT_READY;
        if (go && (opdata2_i == '0)) begin
          state_d = DIV_ZERO;
        end else if (go) begin
          state_d   = DIV_ON;
          cnt_d     = '0;
          acc_d     = {{(WIDTH+1){1'b0}}, abs_val(opdata1_i, signed_i)};
          divisor_d = abs_val(opdata2_i, signed_i);
          signed_d  = signed_i;
          sign1_d   = opdata1_i[WIDTH-1];
          sign2_d   = opdata2_i[WIDTH-1];
        end
      end

      DIV_ZERO: begin
        if (keep) begin
          state_d  = DIV_END;
          result_d = '0;
          ready_d  = DIV_RESULT_READY;
        end else begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end
      end

      DIV_ON: begin
        if (!keep) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end else if (cnt_q == LAST_CNT) begin
          state_d  = DIV_END;
          result_d = {rem_fix, quo_fix};
          ready_d  = DIV_RESULT_READY;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (!trial[WIDTH+1]) begin
            acc_d = {trial[WIDTH:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {acc_q[2*WIDTH-1:0], 1'b0};
          end
        end
      end

      DIV_END: begin
        if (!keep) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end
      end

      default: begin
        state_d  = DIV_FREE;
        result_d = '0;
        ready_d  = DIV_RESULT_NOT_READY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      acc_q     <= '0;
      divisor_q <= '0;
      signed_q  <= 1'b0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      result_q  <= '0;
      ready_q   <= DIV_RESULT_NOT_READY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      divisor_q <= divisor_d;
      signed_q  <= signed_d;
      sign1_q   <= sign1_d;
      sign2_q   <= sign2_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign stall_o  = start_i & ~ready_q;

endmodule
